// File: rtl/vga_sprite_engine.sv
// VGA timing generator with NSPR moving rectangular sprites, priority compositing,
// stop-line motion control and per-frame collision reporting (RGB332 output).
module vga_sprite_engine #(
    parameter int unsigned HPIXELS  = 800,
    parameter int unsigned VLINES   = 521,
    parameter int unsigned HPULSE   = 96,
    parameter int unsigned VPULSE   = 2,
    parameter int unsigned HBP      = 144,
    parameter int unsigned HFP      = 784,
    parameter int unsigned VBP      = 31,
    parameter int unsigned VFP      = 511,
    parameter int unsigned NSPR     = 4,
    parameter int unsigned SPR_L    = 60,
    parameter int unsigned SPR_S    = 30,
    parameter logic [7:0]  BG_COLOR = 8'h1C
) (
    input  logic            dclk,
    input  logic            clr,
    input  logic [NSPR-1:0] go,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_idx,
    input  logic            cfg_en,
    input  logic [9:0]      cfg_x,
    input  logic [9:0]      cfg_y,
    input  logic [1:0]      cfg_dir,
    input  logic [2:0]      cfg_speed,
    input  logic [9:0]      cfg_stop,
    input  logic [7:0]      cfg_color,
    output logic            hsync,
    output logic            vsync,
    output logic [2:0]      red,
    output logic [2:0]      green,
    output logic [1:0]      blue,
    output logic            frame_tick,
    output logic            collide
);

    localparam logic [10:0] HMAX = 11'(HPIXELS - 1);
    localparam logic [10:0] VMAX = 11'(VLINES - 1);
    localparam logic [10:0] HP   = 11'(HPULSE);
    localparam logic [10:0] VP   = 11'(VPULSE);
    localparam logic [10:0] HB   = 11'(HBP);
    localparam logic [10:0] HF   = 11'(HFP);
    localparam logic [10:0] VB   = 11'(VBP);
    localparam logic [10:0] VF   = 11'(VFP);
    localparam logic [10:0] SL   = 11'(SPR_L);
    localparam logic [10:0] SS   = 11'(SPR_S);
    localparam logic [10:0] XMOD = 11'd640;
    localparam logic [10:0] YMOD = 11'd480;

    logic [10:0]     hc_q, vc_q;
    logic [NSPR-1:0] en_q;
    logic [9:0]      x_q     [NSPR];
    logic [9:0]      y_q     [NSPR];
    logic [9:0]      stop_q  [NSPR];
    logic [1:0]      dir_q   [NSPR];
    logic [2:0]      speed_q [NSPR];
    logic [7:0]      color_q [NSPR];
    logic            acc_q;

    logic            active;
    logic [10:0]     px, py;
    logic [7:0]      pix;
    logic            multi;

    // One motion step along an axis, wrapping modulo modv, honouring the stop line unless free.
    function automatic logic [9:0] step(input logic [9:0] pos, input logic [2:0] spd,
                                        input logic [9:0] stp, input logic inc,
                                        input logic free, input logic [10:0] modv);
        logic [10:0] p, s, t, r;
        p = {1'b0, pos};
        s = {8'b0, spd};
        t = {1'b0, stp};
        if (inc) begin
            r = p + s;
            if (r >= modv) r = r - modv;
            if (!free && p < t && p + s >= t) r = t;
        end else begin
            r = (p >= s) ? p - s : p + modv - s;
            if (!free && p > t && p <= t + s) r = t;
        end
        if (!free && p == t) r = p;
        return r[9:0];
    endfunction

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hc_q <= '0;
            vc_q <= '0;
        end else if (hc_q == HMAX) begin
            hc_q <= '0;
            vc_q <= (vc_q == VMAX) ? 11'd0 : vc_q + 11'd1;
        end else begin
            hc_q <= hc_q + 11'd1;
        end
    end

    assign frame_tick = (hc_q == HMAX) && (vc_q == VMAX);
    assign active     = (hc_q >= HB) && (hc_q < HF) && (vc_q >= VB) && (vc_q < VF);
    assign px         = hc_q - HB;
    assign py         = vc_q - VB;

    // Lowest-index hit wins; any further hit on the same pixel flags an overlap.
    always_comb begin
        logic        seen, hit;
        logic [10:0] w, h, x0, y0;
        pix   = BG_COLOR;
        multi = 1'b0;
        seen  = 1'b0;
        hit   = 1'b0;
        w     = '0;
        h     = '0;
        x0    = '0;
        y0    = '0;
        for (int i = 0; i < NSPR; i++) begin
            w   = dir_q[i][0] ? SL : SS;
            h   = dir_q[i][0] ? SS : SL;
            x0  = {1'b0, x_q[i]};
            y0  = {1'b0, y_q[i]};
            hit = en_q[i] && active && (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
            if (hit) begin
                if (!seen) pix = color_q[i];
                else multi = 1'b1;
                seen = 1'b1;
            end
        end
    end

    // A config write to a sprite takes precedence over its motion update on the same edge.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NSPR; i++) begin
                en_q[i]    <= 1'b0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                stop_q[i]  <= '0;
                dir_q[i]   <= '0;
                speed_q[i] <= '0;
                color_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSPR; i++) begin
                if (cfg_we && cfg_idx == 3'(i)) begin
                    en_q[i]    <= cfg_en;
                    x_q[i]     <= cfg_x;
                    y_q[i]     <= cfg_y;
                    stop_q[i]  <= cfg_stop;
                    dir_q[i]   <= cfg_dir;
                    speed_q[i] <= cfg_speed;
                    color_q[i] <= cfg_color;
                end else if (frame_tick && en_q[i]) begin
                    if (dir_q[i][0]) begin
                        x_q[i] <= step(x_q[i], speed_q[i], stop_q[i], dir_q[i] == 2'd1, go[i],
                                       XMOD);
                    end else begin
                        y_q[i] <= step(y_q[i], speed_q[i], stop_q[i], dir_q[i] == 2'd2, go[i],
                                       YMOD);
                    end
                end
            end
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            acc_q   <= 1'b0;
            collide <= 1'b0;
        end else begin
            hsync <= (hc_q >= HP);
            vsync <= (vc_q >= VP);
            {red, green, blue} <= active ? pix : 8'h00;
            if (frame_tick) begin
                collide <= acc_q | multi;
                acc_q   <= 1'b0;
            end else begin
                acc_q <= acc_q | multi;
            end
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a shrunken raster: a pixel model fed from directed sprite
// positions predicts every output cycle, plus directed probes of timing, motion and collisions.
module tb_vga_sprite_engine;

    localparam int HP    = 172;
    localparam int VL    = 12;
    localparam int HPUL  = 12;
    localparam int VPUL  = 2;
    localparam int HBPP  = 20;
    localparam int HFPP  = 170;
    localparam int VBPP  = 2;
    localparam int VFPP  = 11;
    localparam int NS    = 4;
    localparam int SL    = 8;
    localparam int SS    = 4;
    localparam int FRAME = HP * VL;
    localparam logic [7:0] BG = 8'h1C;

    logic          dclk = 1'b0;
    logic          clr  = 1'b1;
    logic [NS-1:0] go   = '0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_idx = '0;
    logic          cfg_en = 1'b0;
    logic [9:0]    cfg_x = '0, cfg_y = '0, cfg_stop = '0;
    logic [1:0]    cfg_dir = '0;
    logic [2:0]    cfg_speed = '0;
    logic [7:0]    cfg_color = '0;
    logic          hsync, vsync, frame_tick, collide;
    logic [2:0]    red, green;
    logic [1:0]    blue;

    int n_tests = 0;
    int n_fail  = 0;

    // Model raster counters and directed sprite state
    int         mhc = 0, mvc = 0;
    logic [9:0] exp_q[$];
    int         m_en[NS], m_x[NS], m_y[NS], m_dir[NS];
    logic [7:0] m_col[NS];

    vga_sprite_engine #(
        .HPIXELS(HP), .VLINES(VL), .HPULSE(HPUL), .VPULSE(VPUL), .HBP(HBPP), .HFP(HFPP),
        .VBP(VBPP), .VFP(VFPP), .NSPR(NS), .SPR_L(SL), .SPR_S(SS), .BG_COLOR(BG)
    ) dut (
        .dclk(dclk), .clr(clr), .go(go), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_dir(cfg_dir), .cfg_speed(cfg_speed),
        .cfg_stop(cfg_stop), .cfg_color(cfg_color), .hsync(hsync), .vsync(vsync), .red(red),
        .green(green), .blue(blue), .frame_tick(frame_tick), .collide(collide)
    );

    always #5 dclk = ~dclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (hc=%0d vc=%0d t=%0t)", tag, got, exp,
                     mhc, mvc, $time);
        end
    endtask

    function automatic logic [9:0] expect_pix(input int h, input int v);
        logic [7:0] c;
        int px, py, w, hh;
        c = 8'h00;
        if (h >= HBPP && h < HFPP && v >= VBPP && v < VFPP) begin
            c  = BG;
            px = h - HBPP;
            py = v - VBPP;
            for (int i = NS - 1; i >= 0; i--) begin
                w  = m_dir[i][0] ? SL : SS;
                hh = m_dir[i][0] ? SS : SL;
                if (m_en[i] != 0 && px >= m_x[i] && px < m_x[i] + w && py >= m_y[i] &&
                    py < m_y[i] + hh) c = m_col[i];
            end
        end
        return {(h >= HPUL), (v >= VPUL), c};
    endfunction

    // Scoreboard producer: the expectation for the pixel described at each edge
    initial begin
        forever begin
            @(posedge dclk or posedge clr);
            if (clr) begin
                mhc = 0;
                mvc = 0;
                exp_q.delete();
            end else begin
                exp_q.push_back(expect_pix(mhc, mvc));
                if (mhc == HP - 1) begin
                    mhc = 0;
                    mvc = (mvc == VL - 1) ? 0 : mvc + 1;
                end else begin
                    mhc++;
                end
            end
        end
    end

    // Scoreboard consumer
    initial begin
        forever begin
            @(negedge dclk);
            if (!clr && exp_q.size() > 0) begin
                check_eq("pix", {hsync, vsync, red, green, blue}, exp_q.pop_front());
                check_eq("tick", frame_tick, (mhc == HP - 1 && mvc == VL - 1));
            end
        end
    end

    task automatic wait_pixel(input int h, input int v);
        int n = 0;
        while (!(mhc == h && mvc == v)) begin
            if (n > FRAME) begin
                check_eq("wait_timeout", (mvc << 16) | mhc, (v << 16) | h);
                return;
            end
            @(negedge dclk);
            n++;
        end
    endtask

    task automatic wait_tick();
        wait_pixel(HP - 1, VL - 1);
        @(posedge dclk);
        #1;
    endtask

    task automatic probe(input string tag, input int h, input int v, input logic [7:0] exp);
        wait_pixel(h, v);
        @(posedge dclk);
        #1;
        check_eq(tag, {red, green, blue}, exp);
    endtask

    task automatic cfg_write(input int idx, input int en, input int x, input int y,
                             input int dir, input int spd, input int stp, input logic [7:0] col);
        @(negedge dclk);
        cfg_idx   = 3'(idx);
        cfg_en    = (en != 0);
        cfg_x     = 10'(x);
        cfg_y     = 10'(y);
        cfg_dir   = 2'(dir);
        cfg_speed = 3'(spd);
        cfg_stop  = 10'(stp);
        cfg_color = col;
        cfg_we    = 1'b1;
        @(posedge dclk);
        #1;
        cfg_we = 1'b0;
        if (idx < NS) begin
            m_en[idx]  = en;
            m_x[idx]   = x;
            m_y[idx]   = y;
            m_dir[idx] = dir;
            m_col[idx] = col;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_en[i]  = 0;
            m_x[i]   = 0;
            m_y[i]   = 0;
            m_dir[i] = 0;
            m_col[i] = 8'h00;
        end
    endtask

    initial begin
        int hs_lo, vs_lo, n_bg, n_blank, ticks, t0, t1, n_red;
        int stop_seq[6] = '{132, 134, 136, 138, 140, 140};
        hs_lo = 0; vs_lo = 0; n_bg = 0; n_blank = 0; ticks = 0; t0 = 0; t1 = 0; n_red = 0;
        model_clear();

        // Reset state
        repeat (3) @(negedge dclk);
        check_eq("rst_sync", {hsync, vsync}, 2'b00);
        check_eq("rst_rgb", {red, green, blue}, 8'h00);
        check_eq("rst_collide", collide, 1'b0);
        clr = 1'b0;

        // Timing over two whole frames, no sprites
        wait_tick();
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge dclk);
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if ({red, green, blue} == BG) n_bg++;
            if ({red, green, blue} == 8'h00) n_blank++;
            if (frame_tick) begin
                if (ticks == 0) t0 = c;
                else t1 = c;
                ticks++;
            end
        end
        check_eq("hsync_low", hs_lo, 2 * VL * HPUL);
        check_eq("vsync_low", vs_lo, 2 * VPUL * HP);
        check_eq("bg_count", n_bg, 2 * (HFPP - HBPP) * (VFPP - VBPP));
        check_eq("blank_count", n_blank, 2 * (FRAME - (HFPP - HBPP) * (VFPP - VBPP)));
        check_eq("tick_count", ticks, 2);
        check_eq("tick_period", t1 - t0, FRAME);
        check_eq("collide_idle", collide, 1'b0);

        // Render and latency
        wait_tick();
        cfg_write(0, 1, 100, 1, 1, 0, 0, 8'hE0);
        probe("rnd_left", 119, 3, BG);
        probe("rnd_first", 120, 3, 8'hE0);
        probe("rnd_last", 127, 3, 8'hE0);
        probe("rnd_right", 128, 3, BG);
        wait_tick();
        cfg_write(0, 1, 100, 1, 0, 0, 0, 8'hE0);
        for (int c = 0; c < FRAME - 20; c++) begin
            @(negedge dclk);
            if ({red, green, blue} == 8'hE0) n_red++;
        end
        check_eq("vert_area", n_red, SS * SL);

        // Stop line
        wait_tick();
        go = '0;
        cfg_write(0, 1, 130, 1, 1, 2, 140, 8'hE0);
        for (int k = 0; k < 6; k++) begin
            wait_tick();
            m_x[0] = stop_seq[k];
            probe("stop_l", HBPP + stop_seq[k] - 1, 3, BG);
            probe("stop_x", HBPP + stop_seq[k], 3, 8'hE0);
        end
        go[0] = 1'b1;
        wait_tick();
        m_x[0] = 142;
        probe("go_l", HBPP + 141, 3, BG);
        probe("go_x", HBPP + 142, 3, 8'hE0);
        go[0] = 1'b0;
        wait_tick();
        m_x[0] = 144;
        probe("past_l", HBPP + 143, 3, BG);
        probe("past_x", HBPP + 144, 3, 8'hE0);
        go[0] = 1'b1;
        cfg_write(0, 1, 639, 1, 1, 2, 140, 8'hE0);
        wait_tick();
        m_x[0] = 1;
        probe("wrap_l", HBPP, 3, BG);
        probe("wrap_x", HBPP + 1, 3, 8'hE0);

        // Priority and collision
        wait_tick();
        m_x[0] = 3;
        check_eq("col_pre", collide, 1'b0);
        cfg_write(0, 1, 20, 1, 1, 0, 0, 8'hE0);
        cfg_write(1, 1, 24, 3, 1, 0, 0, 8'h03);
        probe("col_overlap", HBPP + 26, 5, 8'hE0);
        probe("col_s1", HBPP + 29, 5, 8'h03);
        wait_tick();
        check_eq("col_set", collide, 1'b1);
        cfg_write(1, 1, 100, 3, 1, 0, 0, 8'h03);
        probe("sep_s1", HBPP + 100, 5, 8'h03);
        wait_tick();
        check_eq("col_clear", collide, 1'b0);

        // Out-of-range index
        cfg_write(5, 1, 0, 0, 1, 0, 0, 8'hFF);
        probe("idx5", HBPP, VBPP, BG);

        // Write on the frame_tick cycle
        go = '1;
        wait_tick();
        cfg_write(0, 1, 40, 1, 1, 3, 0, 8'hE0);
        probe("tw_pre", HBPP + 40, 3, 8'hE0);
        wait_pixel(HP - 1, VL - 1);
        check_eq("tw_tick", frame_tick, 1'b1);
        cfg_idx = 3'd0;
        cfg_x   = 10'd60;
        cfg_we  = 1'b1;
        @(posedge dclk);
        #1;
        cfg_we = 1'b0;
        m_x[0] = 60;
        probe("tw_keep_l", HBPP + 59, 3, BG);
        probe("tw_keep", HBPP + 60, 3, 8'hE0);
        wait_tick();
        m_x[0] = 63;
        cfg_write(1, 1, 63, 1, 1, 0, 0, 8'h03);
        probe("tw_move_l", HBPP + 62, 3, BG);
        probe("tw_move", HBPP + 63, 3, 8'hE0);
        wait_tick();
        m_x[0] = 66;
        check_eq("tw_collide", collide, 1'b1);

        // Reset pulse mid-frame, aborting a write in flight
        wait_pixel(HBPP + 50, 6);
        cfg_idx   = 3'd2;
        cfg_en    = 1'b1;
        cfg_x     = 10'd0;
        cfg_y     = 10'd0;
        cfg_dir   = 2'd1;
        cfg_color = 8'hFF;
        cfg_we    = 1'b1;
        clr       = 1'b1;
        model_clear();
        #1;
        check_eq("clr_sync", {hsync, vsync}, 2'b00);
        check_eq("clr_rgb", {red, green, blue}, 8'h00);
        check_eq("clr_collide", collide, 1'b0);
        check_eq("clr_tick", frame_tick, 1'b0);
        @(negedge dclk);
        check_eq("clr_hold", {hsync, vsync, red, green, blue}, 10'h000);
        cfg_we = 1'b0;
        @(negedge dclk);
        clr = 1'b0;
        probe("clr_idx2", HBPP, VBPP, BG);
        probe("clr_s0", HBPP + 66, 3, BG);
        wait_tick();
        check_eq("clr_col_after", collide, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
